// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder over a small byte-addressable store.
// Each accepted request is answered a fixed LATENCY cycles later and held until taken.
module data_mem_responder #(
    parameter int LATENCY     = 2,
    parameter int DEPTH_BYTES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    output logic [63:0] val1,
    output logic [63:0] val2,
    output logic [63:0] val3,
    output logic [63:0] val4,
    output logic [1:0]  dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // the initiator holds its request until it is taken, and the response is held until taken.

    localparam int AW = $clog2(DEPTH_BYTES);
    // WAIT lasts LATENCY-1 cycles; the counter runs down to zero inside it.
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        r_state;
    logic [3:0]    r_cnt;
    logic          r_req_ready;
    logic          r_rsp_valid;
    logic          r_rsp_err;
    logic [63:0]   r_rsp_rdata;
    logic          r_res_err;
    logic [63:0]   r_res_data;
    logic [7:0]    r_mem [DEPTH_BYTES];

    logic          w_accept;
    logic [3:0]    w_nbytes;
    logic [64:0]   w_end;
    logic          w_misaligned;
    logic          w_out_of_range;
    logic          w_err;
    logic [AW-1:0] w_base;
    logic [63:0]   w_raw;
    logic [63:0]   w_load;
    logic [63:0]   w_result;

    assign w_accept = (r_state == S_IDLE) && req_valid;
    assign w_nbytes = 4'd1 << req_size;
    assign w_base   = req_addr[AW-1:0];

    // 65-bit end address so that addresses near 2^64 cannot wrap into range.
    assign w_end          = {1'b0, req_addr} + 65'(w_nbytes);
    assign w_out_of_range = w_end > 65'(DEPTH_BYTES);

    always_comb begin
        w_misaligned = 1'b0;
        case (req_size)
            2'b01:   w_misaligned = req_addr[0];
            2'b10:   w_misaligned = |req_addr[1:0];
            2'b11:   w_misaligned = |req_addr[2:0];
            default: w_misaligned = 1'b0;
        endcase
    end

    assign w_err = w_misaligned || w_out_of_range;

    always_comb begin
        w_raw = '0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < w_nbytes) begin
                w_raw[8*i +: 8] = r_mem[w_base + AW'(i)];
            end
        end
    end

    always_comb begin
        w_load = w_raw;
        case (req_size)
            2'b00:   w_load = req_unsigned ? {56'd0, w_raw[7:0]}
                                           : {{56{w_raw[7]}}, w_raw[7:0]};
            2'b01:   w_load = req_unsigned ? {48'd0, w_raw[15:0]}
                                           : {{48{w_raw[15]}}, w_raw[15:0]};
            2'b10:   w_load = req_unsigned ? {32'd0, w_raw[31:0]}
                                           : {{32{w_raw[31]}}, w_raw[31:0]};
            default: w_load = w_raw;
        endcase
    end

    assign w_result = (w_err || req_write) ? 64'd0 : w_load;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 64'd0;
            r_res_err   <= 1'b0;
            r_res_data  <= 64'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_res_data  <= w_result;
                        r_res_err   <= w_err;
                        r_req_ready <= 1'b0;
                        r_cnt       <= CNT_INIT;
                        if (LATENCY == 1) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= w_result;
                            r_rsp_err   <= w_err;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_res_data;
                        r_rsp_err   <= r_res_err;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= 64'd0;
                        r_rsp_err   <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    // Stores commit at the acceptance edge, so a following load always sees them.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_BYTES; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else if (w_accept && req_write && !w_err) begin
            for (int i = 0; i < 8; i++) begin
                if (4'(i) < w_nbytes) begin
                    r_mem[w_base + AW'(i)] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        val1 = '0;
        val2 = '0;
        val3 = '0;
        val4 = '0;
        for (int i = 0; i < 8; i++) begin
            val1[8*i +: 8] = r_mem[i];
            val2[8*i +: 8] = r_mem[8 + i];
            val3[8*i +: 8] = r_mem[16 + i];
            val4[8*i +: 8] = r_mem[24 + i];
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign dbg_state = r_state;

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter LATENCY, default 2, meaning the number of cycles from request acceptance to rsp_valid (legal 1..15).
REQ-002 The block SHALL have parameter DEPTH_BYTES, default 64, meaning byte-addressable storage size (power of two, at least 32).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  00 byte, 01 half, 10 word, 11 doubleword.
REQ-009 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-010 req_addr  input  64  byte address.
REQ-011 req_wdata  input  64  store data, low-order bytes used.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  initiator takes the response.
REQ-014 rsp_rdata  output  64  load result; 0 for stores and errors.
REQ-015 rsp_err  output  1  request was misaligned or out of range.
REQ-016 val1, val2, val3, val4  output  64 each  debug view of the little-endian doublewords at bytes 0, 8, 16 and 24, updated combinationally from storage.

Function
REQ-017 The FSM SHALL have three states:
- IDLE: req_ready=1.
- WAIT: latency countdown.
- RESP: rsp_valid=1.
REQ-018 A request SHALL be accepted on an edge where state=IDLE and req_valid=1.
- All request fields are captured at that edge.
- req_valid while not IDLE SHALL be ignored; the initiator holds it.
REQ-019 On acceptance the next state SHALL be RESP when LATENCY=1, else WAIT.
- The counter is loaded so that rsp_valid first rises exactly LATENCY cycles after the acceptance cycle.
REQ-020 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until an edge with rsp_ready=1, then the state returns to IDLE.
- Minimum spacing between acceptances is LATENCY+1 cycles.
- rsp_ready outside RESP SHALL be ignored.
REQ-021 An access SHALL be an error when:
- req_addr is not a multiple of 2^req_size, or
- req_addr + 2^req_size > DEPTH_BYTES, evaluated on the full 64-bit address with no wrap-around.
REQ-022 An error access SHALL NOT modify storage and SHALL return rsp_err=1 and rsp_rdata=0.
REQ-023 A legal store SHALL write the low 2^req_size bytes of req_wdata little-endian starting at req_addr, committed at the acceptance edge; other bytes are unchanged.
REQ-024 A legal load SHALL sample the 2^req_size bytes at the acceptance edge, extended per req_unsigned (doubleword unaffected), and return rsp_err=0.
REQ-025 A store response SHALL carry rsp_rdata=0 and rsp_err=0 when legal.
REQ-026 A load following a store to the same address SHALL observe the stored value, because the store commits before the next acceptance is possible.

Reset
REQ-027 While reset=1 at an edge, the block SHALL:
- enter IDLE and clear the counter;
- set all DEPTH_BYTES bytes to 0x00;
- drive rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=1 (visible after the edge).
REQ-028 Reset asserted in WAIT or RESP SHALL abandon the transaction with no response ever issued; reset has priority over acceptance in the same cycle.

Verification
REQ-029 Reset then store: doubleword to addr 0x08 with data 0x1122334455667788 -> rsp_valid exactly 2 cycles after accept, rsp_err=0, val2=0x1122334455667788.
REQ-030 Sign extension: after REQ-029, load byte from 0x0F, signed -> rsp_rdata=0x0000000000000011; store byte 0x80 to 0x10, then load it signed -> 0xFFFFFFFFFFFFFF80, and unsigned -> 0x80.
REQ-031 Errors:
- half load at 0x03 -> rsp_err=1, rdata=0;
- doubleword store at 0x3C (DEPTH_BYTES=64) -> rsp_err=1 and storage unchanged;
- word load at 0xFFFFFFFFFFFFFFFC -> rsp_err=1.
REQ-032 Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stable, req_ready=0, and a concurrent req_valid is not accepted until the cycle after the rsp handshake.
REQ-033 Reset mid-operation: assert reset during WAIT of a store to 0x00 -> no rsp_valid ever, val1=0, next request accepted in the cycle after reset deasserts.
REQ-034 Latency sweep with LATENCY=1 and LATENCY=7 -> rsp_valid rises 1 and 7 cycles after the accept cycle respectively; back-to-back requests with rsp_ready tied high are accepted every LATENCY+1 cycles.
